// File: rtl/bpred_storage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpred_storage_pkg
// Brief    : Shared sizing constants and BTB entry field offsets for the
//            branch-predictor storage block.
// Revision : 1.0 - initial release
// ============================================================================
package bpred_storage_pkg;

    // Instruction memory geometry
    localparam int INSN_AW = 8;
    localparam int INSN_DW = 32;

    // BTB/bimodal table geometry
    localparam int BTB_AW  = 8;
    localparam int LANES   = 4;
    localparam int LANE_W  = 9;
    localparam int BTB_DW  = LANES * LANE_W;

    // BTB entry layout: target[31:2] | bimodal counter | carry bits
    localparam int TARGET_MSB  = 35;
    localparam int TARGET_LSB  = 6;
    localparam int BIMODAL_MSB = 5;
    localparam int BIMODAL_LSB = 4;
    localparam int CARRY_MSB   = 3;
    localparam int CARRY_LSB   = 0;

endpackage : bpred_storage_pkg
`default_nettype wire

// File: rtl/bpred_storage_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Brief    : Simple dual-port synchronous RAM with per-lane write enables,
//            one-cycle read latency, old-data read-during-write and a
//            synchronous clear of the read output register.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter  int AW     = 8,
    parameter  int LANES  = 1,
    parameter  int LANE_W = 32,
    localparam int C_DW   = LANES * LANE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [AW-1:0]    wr_addr,
    input  logic [C_DW-1:0]  wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [C_DW-1:0]  rd_data
);

    localparam int C_DEPTH = 1 << AW;

    // Storage array; contents start at zero and are never touched by reset.
    logic [C_DW-1:0] r_mem [C_DEPTH] = '{default: '0};

    logic [C_DW-1:0] w_rd_data_d;
    logic [C_DW-1:0] r_rd_data_q;

    // Lane-masked write; lanes with a clear enable keep their contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we && be[k]) begin
                r_mem[wr_addr][k*LANE_W +: LANE_W] <= wr_data[k*LANE_W +: LANE_W];
            end
        end
    end

    // Sampling the array before this edge's write lands gives old-data
    // read-during-write; the output is forced to zero while in reset.
    always_comb begin
        w_rd_data_d = r_mem[rd_addr];
        if (reset) begin
            w_rd_data_d = '0;
        end
    end

    // Read data register: the address presented at an edge is reflected here.
    always_ff @(posedge clk) begin
        r_rd_data_q <= w_rd_data_d;
    end

    assign rd_data = r_rd_data_q;

endmodule : sdp_ram
`default_nettype wire

// File: rtl/bpred_storage.sv
`default_nettype none
// ============================================================================
// Module   : bpred_storage
// Brief    : Branch-predictor storage: 256x32 instruction memory and a
//            256x36 BTB/bimodal table with 9-bit lane enables.
// Revision : 1.0 - initial release
// ============================================================================
module bpred_storage
    import bpred_storage_pkg::*;
#(
    parameter int INSN_AW = bpred_storage_pkg::INSN_AW,
    parameter int INSN_DW = bpred_storage_pkg::INSN_DW,
    parameter int BTB_AW  = bpred_storage_pkg::BTB_AW,
    parameter int LANES   = bpred_storage_pkg::LANES,
    parameter int LANE_W  = bpred_storage_pkg::LANE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      insn_wren,
    input  logic [INSN_AW-1:0]        insn_wraddress,
    input  logic [INSN_DW-1:0]        insn_data,
    input  logic [INSN_AW-1:0]        insn_rdaddress,
    output logic [INSN_DW-1:0]        insn_q,
    input  logic                      btb_wren,
    input  logic [LANES-1:0]          btb_byteena,
    input  logic [BTB_AW-1:0]         btb_wraddress,
    input  logic [LANES*LANE_W-1:0]   btb_data,
    input  logic [BTB_AW-1:0]         btb_rdaddress,
    output logic [LANES*LANE_W-1:0]   btb_q
);

    // Instruction memory: always written as a whole word.
    sdp_ram #(
        .AW     (INSN_AW),
        .LANES  (1),
        .LANE_W (INSN_DW)
    ) u_insn_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (insn_wren),
        .be      (1'b1),
        .wr_addr (insn_wraddress),
        .wr_data (insn_data),
        .rd_addr (insn_rdaddress),
        .rd_data (insn_q)
    );

    // BTB/bimodal table: update logic rewrites only the lanes it owns.
    sdp_ram #(
        .AW     (BTB_AW),
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_btb_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (btb_wren),
        .be      (btb_byteena),
        .wr_addr (btb_wraddress),
        .wr_data (btb_data),
        .rd_addr (btb_rdaddress),
        .rd_data (btb_q)
    );

endmodule : bpred_storage
`default_nettype wire

// File: tb/tb_bpred_storage.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpred_storage
// Brief    : Scoreboard bench for bpred_storage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpred_storage;

    logic        clk = 1'b0;
    logic        reset;
    logic        insn_wren;
    logic [7:0]  insn_wraddress;
    logic [31:0] insn_data;
    logic [7:0]  insn_rdaddress;
    logic [31:0] insn_q;
    logic        btb_wren;
    logic [3:0]  btb_byteena;
    logic [7:0]  btb_wraddress;
    logic [35:0] btb_data;
    logic [7:0]  btb_rdaddress;
    logic [35:0] btb_q;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        bit          ci;
        logic [31:0] ei;
        bit          cb;
        logic [35:0] eb;
    } exp_t;

    exp_t exp_q[$];
    bit   req = 1'b0;

    bpred_storage dut (
        .clk            (clk),
        .reset          (reset),
        .insn_wren      (insn_wren),
        .insn_wraddress (insn_wraddress),
        .insn_data      (insn_data),
        .insn_rdaddress (insn_rdaddress),
        .insn_q         (insn_q),
        .btb_wren       (btb_wren),
        .btb_byteena    (btb_byteena),
        .btb_wraddress  (btb_wraddress),
        .btb_data       (btb_data),
        .btb_rdaddress  (btb_rdaddress),
        .btb_q          (btb_q)
    );

    always #5 clk = ~clk;

    // Monitor: for every edge that carried a checked read, compare the
    // outputs shortly after the edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (req) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow: no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    if (e.ci) begin
                        n_tests++;
                        if (insn_q !== e.ei) begin
                            n_fail++;
                            $display("FAIL %s insn_q: got %h expected %h", e.name, insn_q, e.ei);
                        end
                    end
                    if (e.cb) begin
                        n_tests++;
                        if (btb_q !== e.eb) begin
                            n_fail++;
                            $display("FAIL %s btb_q: got %h expected %h", e.name, btb_q, e.eb);
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus; inputs set by the caller are sampled at this edge.
    task automatic tick(input string nm, input bit ci, input logic [31:0] ei,
                        input bit cb, input logic [35:0] eb);
        exp_t e;
        if (ci || cb) begin
            e.name = nm; e.ci = ci; e.ei = ei; e.cb = cb; e.eb = eb;
            exp_q.push_back(e);
            req = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        req       = 1'b0;
        insn_wren = 1'b0;
        btb_wren  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        insn_wren = 1'b0; insn_wraddress = '0; insn_data = '0; insn_rdaddress = '0;
        btb_wren = 1'b0; btb_byteena = '0; btb_wraddress = '0; btb_data = '0; btb_rdaddress = '0;
        @(negedge clk);
        tick("reset_init", 1, 32'h0, 1, 36'h0);
        reset = 1'b0;

        // Instruction RAM write, read-during-write, then readback
        insn_wren = 1; insn_wraddress = 8'h05; insn_data = 32'hDEADBEEF; insn_rdaddress = 8'h05;
        tick("insn_rdw_old", 1, 32'h0, 0, '0);
        insn_rdaddress = 8'h05;
        tick("insn_read05", 1, 32'hDEADBEEF, 0, '0);
        insn_rdaddress = 8'h04;
        tick("insn_read04", 1, 32'h0, 0, '0);

        // BTB full-word write
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'h80; btb_data = 36'h9_ABCD_EF12;
        tick("btb_full_wr", 0, '0, 0, '0);
        btb_rdaddress = 8'h80;
        tick("btb_full_rd", 0, '0, 1, 36'h9_ABCD_EF12);

        // BTB lane writes on an all-ones entry
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'h10; btb_data = 36'hF_FFFF_FFFF;
        tick("btb_preload", 0, '0, 0, '0);
        btb_wren = 1; btb_byteena = 4'b0001; btb_data = '0; btb_rdaddress = 8'h10;
        tick("btb_lane0_old", 0, '0, 1, 36'hF_FFFF_FFFF);
        btb_wren = 1; btb_byteena = 4'b0010; btb_data = '0;
        tick("btb_lane0", 0, '0, 1, 36'hF_FFFF_FE00);
        btb_wren = 1; btb_byteena = 4'b0000; btb_data = '0;
        tick("btb_lane1", 0, '0, 1, 36'hF_FFFC_0000);
        tick("btb_be0_noop", 0, '0, 1, 36'hF_FFFC_0000);

        // BTB read-during-write returns old data
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'h20; btb_data = 36'h11;
        tick("btb_rdw_pre", 0, '0, 0, '0);
        btb_wren = 1; btb_data = 36'h22; btb_rdaddress = 8'h20;
        tick("btb_rdw_old", 0, '0, 1, 36'h11);
        tick("btb_rdw_new", 0, '0, 1, 36'h22);

        // Preload entries 0..3 with nonzero data
        for (int i = 0; i < 4; i++) begin
            insn_wren = 1; insn_wraddress = 8'(i); insn_data = 32'h100 + 32'(i);
            btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'(i); btb_data = 36'h200 + 36'(i);
            tick("preload", 0, '0, 0, '0);
        end

        // Reset held while reads point at populated entries; writes still land
        reset = 1'b1; insn_rdaddress = 8'h05; btb_rdaddress = 8'h80;
        for (int i = 0; i < 4; i++) begin
            insn_wren = 1; insn_wraddress = 8'(i); insn_data = '0;
            btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'(i); btb_data = '0;
            tick("reset_q", 1, 32'h0, 1, 36'h0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            insn_rdaddress = 8'(i); btb_rdaddress = 8'(i);
            tick("reset_swept", 1, 32'h0, 1, 36'h0);
        end
        insn_rdaddress = 8'h05; btb_rdaddress = 8'h80;
        tick("reset_kept", 1, 32'hDEADBEEF, 1, 36'h9_ABCD_EF12);

        // Address extremes do not alias
        insn_wren = 1; insn_wraddress = 8'hFF; insn_data = 32'hAAAA5555;
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'hFF; btb_data = 36'h1_2345_6789;
        tick("wrap_wr_ff", 0, '0, 0, '0);
        insn_wren = 1; insn_wraddress = 8'h00; insn_data = 32'h5555AAAA;
        btb_wren = 1; btb_byteena = 4'hF; btb_wraddress = 8'h00; btb_data = 36'hE_DCBA_9876;
        tick("wrap_wr_00", 0, '0, 0, '0);
        insn_rdaddress = 8'hFF; btb_rdaddress = 8'hFF;
        tick("wrap_rd_ff", 1, 32'hAAAA5555, 1, 36'h1_2345_6789);
        insn_rdaddress = 8'h00; btb_rdaddress = 8'h00;
        tick("wrap_rd_00", 1, 32'h5555AAAA, 1, 36'hE_DCBA_9876);

        // Drain: every queued expectation must have been consumed
        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_bpred_storage
`default_nettype wire
